// File: rtl/automaton_param_if.sv
// ---------------------------------------------------------------------------
// automaton_param_if
// World memory bus between the cellular automaton engine and the cell store.
//   row, col   : cell address, driven by the engine from registers
//   world_we   : 1 = write world_out at row/col, 0 = read
//   world_in   : cell value at row/col, returned combinationally
//   world_out  : new cell value, meaningful only while world_we = 1
// Modports: master = engine side, slave = memory side.
// ---------------------------------------------------------------------------
interface automaton_param_if #(
  parameter int RW = 6,
  parameter int CW = 6
);
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          world_we;
  logic          world_in;
  logic          world_out;

  modport master (
    output row, col, world_we, world_out,
    input  world_in
  );

  modport slave (
    input  row, col, world_we, world_out,
    output world_in
  );
endinterface

// File: rtl/automaton_param.sv
// ---------------------------------------------------------------------------
// automaton_param
// One-dimensional-rule 2D cellular automaton engine. Each generation scans the
// world row by row through a 3-row line buffer, so every new cell is computed
// from pre-update neighbours while results are written back in place.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begin a run (IDLE only); samples gens, wrap, rule
//   gens              : generations to run, 0 = free-run
//   wrap              : 0 = zero-padded edges, 1 = toroidal edges
//   rule              : 32-entry next-state table indexed by {N,W,C,E,S}
//   abort             : drop the current run and return to IDLE
//   wb                : world memory bus (row, col, world_we, world_in, world_out)
//   busy              : run in progress
//   update_done       : one-cycle pulse per completed generation
//   run_done          : one-cycle pulse when a finite run completes
//   gen_cnt           : generations completed in the current run
// ---------------------------------------------------------------------------
module automaton_param #(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int RW   = 6,
  parameter int CW   = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [15:0]            gens,
  input  logic                   wrap,
  input  logic [31:0]            rule,
  input  logic                   abort,
  automaton_param_if.master      wb,
  output logic                   busy,
  output logic                   update_done,
  output logic                   run_done,
  output logic [15:0]            gen_cnt
);

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_PEN  = RW'(ROWS - 2);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state, state_nx;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [COLS-1:0]   nb, cb, sb;   // north / centre / south line buffers
  logic [COLS-1:0]   r0;           // original row 0, south of the last row in wrap mode
  logic [31:0]       rule_q;
  logic [15:0]       gens_q;
  logic              wrap_q;
  logic              col_last, last_gen, gen_begin;
  logic              n_bit, w_bit, c_bit, e_bit, s_bit;
  logic [4:0]        idx;

  assign col_last  = (col_q == COL_LAST);
  assign last_gen  = (gens_q != 16'd0) && ((gen_cnt + 16'd1) == gens_q);
  assign gen_begin = ((state == S_IDLE) || (state == S_DONE)) &&
                     ((state_nx == S_PRE) || (state_nx == S_READ));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = wrap ? S_PRE : S_READ;
      S_PRE:   if (col_last) state_nx = S_READ;
      // Row 0 read is followed by row 1 read before the first write.
      S_READ:  if (col_last) state_nx = (row_q == '0) ? S_READ : S_WRITE;
      // The last row needs no read: its south comes from zeros or r0.
      S_WRITE: if (col_last) state_nx = (row_q == ROW_LAST) ? S_DONE :
                                        (row_q == ROW_PEN)  ? S_WRITE : S_READ;
      S_DONE:  state_nx = last_gen ? S_IDLE : (wrap_q ? S_PRE : S_READ);
      default: state_nx = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nx = S_IDLE;
  end

  // Output logic
  always_comb begin
    busy         = (state != S_IDLE);
    wb.world_we  = (state == S_WRITE);
    wb.world_out = (state == S_WRITE) & rule_q[idx];
    update_done  = (state == S_DONE);
    run_done     = (state == S_DONE) & last_gen;
  end

  assign wb.row = row_q;
  assign wb.col = col_q;

  // Run configuration, captured once per accepted start
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && start) begin
      rule_q <= rule;
      gens_q <= gens;
      wrap_q <= wrap;
    end
  end

  // Scan address, line buffers and generation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      nb      <= '0;
      cb      <= '0;
      sb      <= '0;
      r0      <= '0;
      gen_cnt <= '0;
    end else begin
      if ((state_nx == S_IDLE) || (state_nx == S_DONE)) begin
        row_q <= '0;
        col_q <= '0;
      end else if (gen_begin) begin
        row_q <= (state_nx == S_PRE) ? ROW_LAST : '0;
        col_q <= '0;
      end else if (col_last) begin
        col_q <= '0;
        unique case (state)
          S_PRE:   row_q <= '0;
          S_READ:  row_q <= (row_q == '0) ? RW'(1) : row_q - RW'(1);
          S_WRITE: row_q <= (row_q == ROW_PEN) ? row_q + RW'(1) : row_q + RW'(2);
          default: row_q <= row_q;
        endcase
      end else begin
        col_q <= col_q + CW'(1);
      end

      // North must read as zero in zero mode; PRE overwrites it in wrap mode.
      if (gen_begin) nb <= '0;

      if (state == S_PRE) nb[col_q] <= wb.world_in;

      if (state == S_READ) begin
        if (row_q == '0) begin
          cb[col_q] <= wb.world_in;
          r0[col_q] <= wb.world_in;
        end else begin
          sb[col_q] <= wb.world_in;
        end
      end

      // Roll the window down one row after each row except the last.
      if ((state == S_WRITE) && col_last && (row_q != ROW_LAST)) begin
        nb <= cb;
        cb <= sb;
        if (row_q == ROW_PEN) sb <= wrap_q ? r0 : '0;
      end

      if ((state == S_IDLE) && start) gen_cnt <= '0;
      else if (state == S_DONE)       gen_cnt <= gen_cnt + 16'd1;
    end
  end

  // Neighbourhood of the cell being written
  always_comb begin
    n_bit = nb[col_q];
    c_bit = cb[col_q];
    s_bit = sb[col_q];
    w_bit = (col_q == '0) ? (wrap_q & cb[COLS-1]) : cb[col_q - CW'(1)];
    e_bit = col_last      ? (wrap_q & cb[0])      : cb[col_q + CW'(1)];
    idx   = {n_bit, w_bit, c_bit, e_bit, s_bit};
  end

endmodule

// File: tb/tb_automaton_param.sv
module tb_automaton_param;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int RW   = 3;
  localparam int CW   = 3;

  localparam logic [31:0] R_ID = 32'hF0F0_F0F0;
  localparam logic [31:0] R_W  = 32'hFF00_FF00;
  localparam logic [31:0] R_N  = 32'hFFFF_0000;
  localparam logic [63:0] IMG  = 64'hDEAD_BEEF_0123_4567;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        wrap = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] gens = 16'd0;
  logic [31:0] rule = 32'd0;
  logic        busy, update_done, run_done;
  logic [15:0] gen_cnt;

  logic [63:0] mem;
  logic [63:0] load_img = 64'd0;
  logic        load_req = 1'b0;
  logic [63:0] snap;

  int checks = 0;
  int errors = 0;
  int pulse_at [8];
  int npulse, nrd, rd_at, first_we, nwe;

  automaton_param_if #(.RW(RW), .CW(CW)) wb();

  automaton_param #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gens(gens), .wrap(wrap),
    .rule(rule), .abort(abort), .wb(wb), .busy(busy),
    .update_done(update_done), .run_done(run_done), .gen_cnt(gen_cnt)
  );

  always #5 clk = ~clk;

  // World store: bit index = row*8 + col
  always @(posedge clk) begin
    if (load_req)         mem <= load_img;
    else if (wb.world_we) mem[{wb.row, wb.col}] <= wb.world_out;
  end
  assign wb.world_in = mem[{wb.row, wb.col}];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row"},  64'(wb.row), 64'd0);
    check({tag, "_col"},  64'(wb.col), 64'd0);
    check({tag, "_we"},   64'(wb.world_we), 64'd0);
    check({tag, "_out"},  64'(wb.world_out), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_upd"},  64'(update_done), 64'd0);
    check({tag, "_rdn"},  64'(run_done), 64'd0);
    check({tag, "_gcnt"}, 64'(gen_cnt), 64'd0);
  endtask

  task automatic load(input logic [63:0] img);
    @(negedge clk);
    load_img = img;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Starts a run and observes it until busy drops; n counts rising edges
  // from the one that samples start. A second start with different
  // settings is pulsed at n == restart_at (0 = none).
  task automatic run(input logic [31:0] r, input logic w, input logic [15:0] g,
                     input int budget, input int restart_at);
    @(negedge clk);
    rule = r; wrap = w; gens = g; start = 1'b1;
    npulse = 0; nrd = 0; rd_at = 0; first_we = 0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == restart_at) begin
        rule = ~r; wrap = ~w; gens = g + 16'd4; start = 1'b1;
      end
      if (update_done && npulse < 8) begin pulse_at[npulse] = n; npulse++; end
      if (run_done) begin nrd++; rd_at = n; end
      if (wb.world_we && first_we == 0) first_we = n;
      if (!busy) break;
    end
    start = 1'b0;
    check("run_ends", 64'(busy), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) pulse_at[i] = 0;

    // Power-on reset
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Identity rule, three finite generations, zero edges
    load(IMG);
    run(R_ID, 1'b0, 16'd3, 2000, 0);
    check("id_npulse", 64'(npulse), 64'd3);
    check("id_pulse1", 64'(pulse_at[0]), 64'd129);
    check("id_pulse2", 64'(pulse_at[1]), 64'd258);
    check("id_pulse3", 64'(pulse_at[2]), 64'd387);
    check("id_nrd", 64'(nrd), 64'd1);
    check("id_rd_at", 64'(rd_at), 64'd387);
    check("id_gcnt", 64'(gen_cnt), 64'd3);
    check("id_first_we", 64'(first_we), 64'd17);
    check("id_world", mem, IMG);

    // Copy-west, single cell at (2,7)
    load(64'h0000_0000_0080_0000);
    run(R_W, 1'b1, 16'd1, 500, 0);
    check("cw_wrap_pulse", 64'(pulse_at[0]), 64'd137);
    check("cw_wrap_rd_at", 64'(rd_at), 64'd137);
    check("cw_wrap_first_we", 64'(first_we), 64'd25);
    check("cw_wrap_world", mem, 64'h0000_0000_0001_0000);
    load(64'h0000_0000_0080_0000);
    run(R_W, 1'b0, 16'd1, 500, 0);
    check("cw_zero_pulse", 64'(pulse_at[0]), 64'd129);
    check("cw_zero_world", mem, 64'd0);

    // Copy-north, single cell at (7,2)
    load(64'h0400_0000_0000_0000);
    run(R_N, 1'b1, 16'd1, 500, 0);
    check("cn_wrap_world", mem, 64'h0000_0000_0000_0004);
    check("cn_wrap_gcnt", 64'(gen_cnt), 64'd1);
    load(64'h0400_0000_0000_0000);
    run(R_N, 1'b0, 16'd1, 500, 0);
    check("cn_zero_world", mem, 64'd0);

    // Start while busy with different settings must be ignored
    load(IMG);
    run(R_ID, 1'b0, 16'd1, 500, 40);
    check("rs_npulse", 64'(npulse), 64'd1);
    check("rs_pulse", 64'(pulse_at[0]), 64'd129);
    check("rs_gcnt", 64'(gen_cnt), 64'd1);
    check("rs_world", mem, IMG);

    // Free run, abort after the fifth generation
    load(IMG);
    @(negedge clk);
    rule = R_ID; wrap = 1'b0; gens = 16'd0; start = 1'b1;
    npulse = 0; nrd = 0;
    for (int n = 1; n <= 1000 && npulse < 5; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (update_done) begin pulse_at[npulse] = n; npulse++; end
      if (run_done) nrd++;
    end
    check("fr_pulse1", 64'(pulse_at[0]), 64'd129);
    check("fr_pulse5", 64'(pulse_at[4]), 64'd645);
    @(negedge clk);
    check("fr_busy_pre", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_we", 64'(wb.world_we), 64'd0);
    check("ab_upd", 64'(update_done), 64'd0);
    check("ab_gcnt", 64'(gen_cnt), 64'd5);
    check("ab_nrd", 64'(nrd), 64'd0);
    check("ab_world", mem, IMG);

    // Reset in the middle of a write
    load(IMG);
    @(negedge clk);
    rule = R_ID; wrap = 1'b0; gens = 16'd0; start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n > 140 && wb.world_we) break;
    end
    check("mw_in_write", 64'(wb.world_we), 64'd1);
    check("mw_gcnt_pre", 64'(gen_cnt), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mw");
    snap = mem;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nwe = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (wb.world_we) nwe++;
    end
    check("mw_no_writes", 64'(nwe), 64'd0);
    check("mw_idle", 64'(busy), 64'd0);
    check("mw_world", mem, snap);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
